// File: rtl/data_in_64to8_serializer.sv
// ============================================================================
// Module     : data_in_64to8_serializer
// Description: Splits a latched 64-bit word into bytes for a byte-wide UART TX.
//              Define DATA_IN_64TO8_MSB_FIRST_EN to send the MSB byte first.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_in_64to8_serializer #(
  parameter int WORD_W = 64,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_64,
  input  logic              data_in_enable,
  input  logic              manual_start,
  output logic [BYTE_W-1:0] data_8,
  output logic              tx_enable
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] word_reg;
  logic [IDX_W-1:0]  byte_idx;
  logic              en_prev;
  logic              start_prev;

  logic start_rise;
  logic en_rise;
  logic launch;

  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w, input int k);
`ifdef DATA_IN_64TO8_MSB_FIRST_EN
    return w[WORD_W-1-k*BYTE_W -: BYTE_W];
`else
    return w[k*BYTE_W +: BYTE_W];
`endif
  endfunction

  assign start_rise = manual_start & ~start_prev;
  assign en_rise    = data_in_enable & ~en_prev;
  // Restart wins over byte advance; a DONE word relaunches on either strobe.
  assign launch     = start_rise | ((state == DONE) & en_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_reg   <= '0;
      byte_idx   <= '0;
      data_8     <= '0;
      tx_enable  <= 1'b0;
      en_prev    <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      en_prev    <= data_in_enable;
      start_prev <= manual_start;
      tx_enable  <= 1'b0;
      if (launch) begin
        word_reg  <= data_64;
        data_8    <= pick_byte(data_64, 0);
        byte_idx  <= IDX_ONE;
        tx_enable <= 1'b1;
        state     <= ACTIVE;
      end else begin
        case (state)
          IDLE: ;
          ACTIVE: begin
            if (en_rise) begin
              data_8    <= pick_byte(word_reg, int'(byte_idx));
              tx_enable <= 1'b1;
              // Index saturates on the last byte; only a relaunch resets it.
              if (byte_idx == LAST_IDX) state <= DONE;
              else                      byte_idx <= byte_idx + IDX_ONE;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_in_64to8_serializer.sv
// ============================================================================
// Module     : tb_data_in_64to8_serializer
// Description: Directed self-checking bench for data_in_64to8_serializer.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_in_64to8_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_64 = '0;
  logic        data_in_enable = 1'b0;
  logic        manual_start = 1'b0;
  logic [7:0]  data_8;
  logic        tx_enable;

  int n_assert = 0;
  int n_fail   = 0;

  data_in_64to8_serializer #(.WORD_W(64), .BYTE_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_64        (data_64),
    .data_in_enable (data_in_enable),
    .manual_start   (manual_start),
    .data_8         (data_8),
    .tx_enable      (tx_enable)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] WA = 64'hbb941c2b7e1d731b;
  localparam logic [63:0] WB = 64'hbca16b888f3cafb4;
  localparam logic [63:0] WC = 64'h0123456789abcdef;
  localparam logic [63:0] WD = 64'hfedcba9876543210;

`ifdef DATA_IN_64TO8_MSB_FIRST_EN
  logic [7:0] exp_a [8] = '{8'hbb, 8'h94, 8'h1c, 8'h2b, 8'h7e, 8'h1d, 8'h73, 8'h1b};
  logic [7:0] exp_b [8] = '{8'hbc, 8'ha1, 8'h6b, 8'h88, 8'h8f, 8'h3c, 8'haf, 8'hb4};
  logic [7:0] exp_c [3] = '{8'h01, 8'h23, 8'h45};
  logic [7:0] exp_d [2] = '{8'hfe, 8'hdc};
  logic [7:0] exp_a1    = 8'h94;
`else
  logic [7:0] exp_a [8] = '{8'h1b, 8'h73, 8'h1d, 8'h7e, 8'h2b, 8'h1c, 8'h94, 8'hbb};
  logic [7:0] exp_b [8] = '{8'hb4, 8'haf, 8'h3c, 8'h8f, 8'h88, 8'h6b, 8'ha1, 8'hbc};
  logic [7:0] exp_c [3] = '{8'hef, 8'hcd, 8'hab};
  logic [7:0] exp_d [2] = '{8'h10, 8'h32};
  logic [7:0] exp_a1    = 8'h73;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Two-cycle strobe pulse; checks the edge that samples the rise and the one after.
  task automatic pulse(input bit s, input bit e, input bit exp_tx,
                       input logic [7:0] exp_byte, input string tag);
    @(negedge clk);
    manual_start   = s;
    data_in_enable = e;
    @(posedge clk); #1;
    check({tag, " tx"}, {63'd0, tx_enable}, {63'd0, exp_tx});
    check({tag, " data"}, {56'd0, data_8}, {56'd0, exp_byte});
    @(posedge clk); #1;
    check({tag, " tx_single"}, {63'd0, tx_enable}, 64'd0);
    check({tag, " data_hold"}, {56'd0, data_8}, {56'd0, exp_byte});
    @(negedge clk);
    manual_start   = 1'b0;
    data_in_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset and idle quiet period
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle tx", {63'd0, tx_enable}, 64'd0);
      check("idle data", {56'd0, data_8}, 64'd0);
    end

    // data_in_enable ignored in IDLE
    pulse(1'b0, 1'b1, 1'b0, 8'h00, "idle_en0");
    pulse(1'b0, 1'b1, 1'b0, 8'h00, "idle_en1");

    // Word A; data_64 changed mid-word must not matter
    data_64 = WA;
    pulse(1'b1, 1'b0, 1'b1, exp_a[0], "A0");
    data_64 = WD;
    for (int k = 1; k < 8; k++) pulse(1'b0, 1'b1, 1'b1, exp_a[k], $sformatf("A%0d", k));

    // Word B relaunched from DONE by data_in_enable
    data_64 = WB;
    for (int k = 0; k < 8; k++) pulse(1'b0, 1'b1, 1'b1, exp_b[k], $sformatf("B%0d", k));
    repeat (5) @(negedge clk);
    check("done tx", {63'd0, tx_enable}, 64'd0);
    check("done hold", {56'd0, data_8}, {56'd0, exp_b[7]});

    // Abort word C after 3 bytes with a restart carrying D
    data_64 = WC;
    pulse(1'b1, 1'b0, 1'b1, exp_c[0], "C0");
    pulse(1'b0, 1'b1, 1'b1, exp_c[1], "C1");
    pulse(1'b0, 1'b1, 1'b1, exp_c[2], "C2");
    data_64 = WD;
    pulse(1'b1, 1'b0, 1'b1, exp_d[0], "D0");
    pulse(1'b0, 1'b1, 1'b1, exp_d[1], "D1");

    // Simultaneous rises: restart wins, exactly one byte issued
    data_64 = WA;
    pulse(1'b1, 1'b1, 1'b1, exp_a[0], "both");
    pulse(1'b0, 1'b1, 1'b1, exp_a1, "both_next");

    // Asynchronous reset between clock edges
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async rst tx", {63'd0, tx_enable}, 64'd0);
    check("async rst data", {56'd0, data_8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse(1'b0, 1'b1, 1'b0, 8'h00, "post_rst_en");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
